// File: rtl/bp_be_reservation_queue_pkg.sv
// rtl/bp_be_reservation_queue_pkg.sv - shared types, widths and FP recoding helpers for the BE reservation queue
//
// Purpose: dispatch packet and reservation structs, register tag enums, and
// the raw-IEEE to recoded-float conversions used when unboxing FP sources.
// Ports: none (package).

package bp_be_reservation_queue_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int vaddr_width_gp   = 39;
  localparam int dpath_width_gp   = 64;
  localparam int int_rec_width_gp = 65;
  localparam int fp_rec_width_gp  = 65;

  // Recoded single-precision canonical NaN (sign 0, exp 111_000000, quiet bit).
  localparam logic [32:0] sp_canonical_nan_rec = 33'h0_E040_0000;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  typedef enum logic {e_int_dword = 1'b0, e_int_word = 1'b1} bp_be_int_tag_e;
  typedef enum logic {e_fp_dp = 1'b0, e_fp_sp = 1'b1} bp_be_fp_tag_e;

  typedef struct packed {
    logic [5:0]     fu_op;
    bp_be_int_tag_e irs1_tag;
    logic           irs1_unsigned;
    bp_be_int_tag_e irs2_tag;
    logic           irs2_unsigned;
    bp_be_fp_tag_e  frs1_tag;
    bp_be_fp_tag_e  frs2_tag;
    bp_be_fp_tag_e  frs3_tag;
    logic           fmove_v;
  } bp_be_decode_s;

  typedef struct packed {
    logic                       v;
    logic [vaddr_width_gp-1:0]  pc;
    logic [31:0]                instr;
    bp_be_decode_s              decode;
    logic [1:0]                 size;
    logic [1:0]                 count;
    logic [dpath_width_gp-1:0]  rs1;
    logic [dpath_width_gp-1:0]  rs2;
    logic [dpath_width_gp-1:0]  imm;
  } bp_be_dispatch_pkt_s;

  typedef struct packed {
    logic                        v;
    logic [vaddr_width_gp-1:0]   pc;
    logic [31:0]                 instr;
    bp_be_decode_s               decode;
    logic [1:0]                  size;
    logic [1:0]                  count;
    logic [int_rec_width_gp-1:0] isrc1;
    logic [int_rec_width_gp-1:0] isrc2;
    logic [int_rec_width_gp-1:0] isrc3;
    logic [fp_rec_width_gp-1:0]  fsrc1;
    logic [fp_rec_width_gp-1:0]  fsrc2;
    logic [fp_rec_width_gp-1:0]  fsrc3;
  } bp_be_reservation_s;

  // Recoded format: {sign, exp+1 bit, fraction}. Top 3 exp bits 000 = zero,
  // 110 = inf, 111 = NaN; subnormals are normalised into the wider exponent.
  function automatic logic [32:0] rec_sp(input logic [31:0] f);
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  nd;
    e  = f[30:23];
    m  = f[22:0];
    nd = '0;
    for (int i = 0; i < 23; i++) if (m[i]) nd = 5'(22 - i);
    if (e == '0 && m == '0) return {f[31], 32'b0};
    if (e == '1)            return {f[31], (m == '0) ? 3'b110 : 3'b111, 6'b0, m};
    if (e == '0)            return {f[31], 9'd129 - 9'(nd), m << (nd + 5'd1)};
    return {f[31], 9'(e) + 9'd129, m};
  endfunction

  function automatic logic [64:0] rec_dp(input logic [63:0] f);
    logic [10:0] e;
    logic [51:0] m;
    logic [5:0]  nd;
    e  = f[62:52];
    m  = f[51:0];
    nd = '0;
    for (int i = 0; i < 52; i++) if (m[i]) nd = 6'(51 - i);
    if (e == '0 && m == '0) return {f[63], 64'b0};
    if (e == '1)            return {f[63], (m == '0) ? 3'b110 : 3'b111, 9'b0, m};
    if (e == '0)            return {f[63], 12'd1025 - 12'(nd), m << (nd + 6'd1)};
    return {f[63], 12'(e) + 12'd1025, m};
  endfunction

endpackage

// File: rtl/bp_be_fp_unbox.sv
// rtl/bp_be_fp_unbox.sv - convert a raw FP register value to recoded form
//
// Ports: tag_i (sp/dp), raw_i (pass bits through untouched), reg_i, val_o.

module bp_be_fp_unbox
  import bp_be_reservation_queue_pkg::*;
  (input  bp_be_fp_tag_e              tag_i
  ,input  logic                       raw_i
  ,input  logic [dpath_width_gp-1:0]  reg_i
  ,output logic [fp_rec_width_gp-1:0] val_o
  );

  always_comb begin
    val_o = '0;
    if (raw_i)
      val_o = {1'b0, reg_i};
    else if (tag_i == e_fp_dp)
      val_o = rec_dp(reg_i);
    // A single is only legal when NaN-boxed; anything else reads as canonical NaN.
    else
      val_o = {32'b0, (reg_i[63:32] == '1) ? rec_sp(reg_i[31:0]) : sp_canonical_nan_rec};
  end

endmodule

// File: rtl/bp_be_int_unbox.sv
// rtl/bp_be_int_unbox.sv - sign/zero-extend an integer source to the recoded int width
//
// Ports: tag_i (word/dword), unsigned_i, reg_i (raw register), val_o (extended value).

module bp_be_int_unbox
  import bp_be_reservation_queue_pkg::*;
  (input  bp_be_int_tag_e              tag_i
  ,input  logic                        unsigned_i
  ,input  logic [dpath_width_gp-1:0]   reg_i
  ,output logic [int_rec_width_gp-1:0] val_o
  );

  always_comb begin
    val_o = '0;
    if (tag_i == e_int_word)
      val_o = unsigned_i ? {33'b0, reg_i[31:0]} : {{33{reg_i[31]}}, reg_i[31:0]};
    else
      val_o = unsigned_i ? {1'b0, reg_i} : {reg_i[63], reg_i};
  end

endmodule

// File: rtl/bp_be_reservation_unbox.sv
// rtl/bp_be_reservation_unbox.sv - map a dispatch packet to an unboxed reservation
//
// Ports: pkt_i (dispatch packet with final rs1/rs2/imm), reservation_o (unboxed view).

module bp_be_reservation_unbox
  import bp_be_reservation_queue_pkg::*;
  (input  bp_be_dispatch_pkt_s pkt_i
  ,output bp_be_reservation_s  reservation_o
  );

  logic [int_rec_width_gp-1:0] isrc1, isrc2;
  logic [fp_rec_width_gp-1:0]  fsrc1, fsrc2, fsrc3;

  bp_be_int_unbox u_irs1
    (.tag_i(pkt_i.decode.irs1_tag), .unsigned_i(pkt_i.decode.irs1_unsigned), .reg_i(pkt_i.rs1), .val_o(isrc1));
  bp_be_int_unbox u_irs2
    (.tag_i(pkt_i.decode.irs2_tag), .unsigned_i(pkt_i.decode.irs2_unsigned), .reg_i(pkt_i.rs2), .val_o(isrc2));

  bp_be_fp_unbox u_frs1
    (.tag_i(pkt_i.decode.frs1_tag), .raw_i(pkt_i.decode.fmove_v), .reg_i(pkt_i.rs1), .val_o(fsrc1));
  bp_be_fp_unbox u_frs2
    (.tag_i(pkt_i.decode.frs2_tag), .raw_i(pkt_i.decode.fmove_v), .reg_i(pkt_i.rs2), .val_o(fsrc2));
  bp_be_fp_unbox u_frs3
    (.tag_i(pkt_i.decode.frs3_tag), .raw_i(pkt_i.decode.fmove_v), .reg_i(pkt_i.imm), .val_o(fsrc3));

  always_comb begin
    reservation_o        = '0;
    reservation_o.v      = pkt_i.v;
    reservation_o.pc     = pkt_i.pc;
    reservation_o.instr  = pkt_i.instr;
    reservation_o.decode = pkt_i.decode;
    reservation_o.size   = pkt_i.size;
    reservation_o.count  = pkt_i.count;
    reservation_o.isrc1  = isrc1;
    reservation_o.isrc2  = isrc2;
    reservation_o.isrc3  = {1'b0, pkt_i.imm};
    reservation_o.fsrc1  = fsrc1;
    reservation_o.fsrc2  = fsrc2;
    reservation_o.fsrc3  = fsrc3;
  end

endmodule

// File: rtl/bp_be_reservation_queue.sv
// rtl/bp_be_reservation_queue.sv - in-order multi-entry reservation queue feeding the calculator pipes
//
// Purpose: captures dispatch packets (with bypassed rs1/rs2/imm) into an
// els_p-deep FIFO and presents the head entry unboxed.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   dispatch_pkt_i/_v_i       incoming packet and valid; ready_o = space available
//   bypass_rs_i[0..2]         bypassed rs1, rs2, imm for the entering packet
//   flush_i                   drop every entry
//   reservation_o/_v_o        unboxed head entry and its presence
//   yumi_i                    consumer takes the head
//   count_o                   occupancy

module bp_be_reservation_queue
  import bp_be_reservation_queue_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   ,parameter int els_p = 2
   ,localparam int dispatch_pkt_width_lp = $bits(bp_be_dispatch_pkt_s)
   ,localparam int reservation_width_lp  = $bits(bp_be_reservation_s)
   ,localparam int count_width_lp        = $clog2(els_p + 1)
   )
  (input  logic                                 clk_i
  ,input  logic                                 reset_i
  ,input  logic [dispatch_pkt_width_lp-1:0]     dispatch_pkt_i
  ,input  logic                                 dispatch_v_i
  ,output logic                                 ready_o
  ,input  logic [2:0][dpath_width_gp-1:0]       bypass_rs_i
  ,input  logic                                 flush_i
  ,output logic [reservation_width_lp-1:0]      reservation_o
  ,output logic                                 reservation_v_o
  ,input  logic                                 yumi_i
  ,output logic [count_width_lp-1:0]            count_o
  );

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  bp_be_dispatch_pkt_s entering, head;
  bp_be_reservation_s  unboxed;
  bp_be_dispatch_pkt_s mem_r [els_p];

  logic [ptr_width_lp-1:0]   rd_ptr_r, wr_ptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    entering     = dispatch_pkt_i;
    entering.rs1 = bypass_rs_i[0];
    entering.rs2 = bypass_rs_i[1];
    entering.imm = bypass_rs_i[2];
  end

  // ready ignores yumi so a full queue never accepts in the same cycle it drains.
  assign ready_o         = ~reset_i & (count_r < count_width_lp'(els_p));
  assign reservation_v_o = ~reset_i & (count_r != '0);
  assign count_o         = reset_i ? '0 : count_r;
  assign enq             = dispatch_v_i & ready_o & ~flush_i;
  assign deq             = yumi_i & reservation_v_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (enq & ~deq)      count_r <= count_r + 1'b1;
      else if (deq & ~enq) count_r <= count_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= entering;
  end

  assign head = mem_r[rd_ptr_r];

  bp_be_reservation_unbox u_unbox (.pkt_i(head), .reservation_o(unboxed));

  assign reservation_o = reservation_v_o ? unboxed : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (bp_vaddr_width(bp_params_p) == vaddr_width_gp);
      assert (!yumi_i || reservation_v_o);
    end
  end

endmodule

// File: tb/tb_bp_be_reservation_queue.sv
// tb/tb_bp_be_reservation_queue.sv - scoreboard bench for the reservation queue (depths 2 and 3)

module tb_bp_be_reservation_queue;
  import bp_be_reservation_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  bp_be_dispatch_pkt_s  pkt;
  logic [2:0][63:0]     bypass;
  logic                 dv[2], flush[2], yumi[2], ready[2], rv[2];
  bp_be_reservation_s   res[2];
  logic [1:0]           cnt[2];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [38:0] pc;
    logic [64:0] isrc1;
    logic [64:0] fsrc1;
  } exp_t;
  exp_t q0[$], q1[$];

  bp_be_reservation_queue #(.bp_params_p(e_bp_default_cfg), .els_p(2)) u_dut2
    (.clk_i(clk), .reset_i(reset), .dispatch_pkt_i(pkt), .dispatch_v_i(dv[0]), .ready_o(ready[0])
    ,.bypass_rs_i(bypass), .flush_i(flush[0]), .reservation_o(res[0]), .reservation_v_o(rv[0])
    ,.yumi_i(yumi[0]), .count_o(cnt[0]));

  bp_be_reservation_queue #(.bp_params_p(e_bp_default_cfg), .els_p(3)) u_dut3
    (.clk_i(clk), .reset_i(reset), .dispatch_pkt_i(pkt), .dispatch_v_i(dv[1]), .ready_o(ready[1])
    ,.bypass_rs_i(bypass), .flush_i(flush[1]), .reservation_o(res[1]), .reservation_v_o(rv[1])
    ,.yumi_i(yumi[1]), .count_o(cnt[1]));

  function automatic int els(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bp_be_dispatch_pkt_s mk(input logic [38:0] pc);
    bp_be_dispatch_pkt_s p;
    p = '0;
    p.v = 1'b1;
    p.pc = pc;
    p.instr = {pc[29:0], 2'b11};
    p.decode.fmove_v = 1'b1;
    p.rs1 = '1;
    p.rs2 = '1;
    p.imm = '1;
    return p;
  endfunction

  // One clock of stimulus for DUT d, entered and left at a negedge.
  task automatic cycle(input int d, input bit en, input bp_be_dispatch_pkt_s p, input logic [63:0] rs1,
                       input logic [64:0] ei1, input logic [64:0] ef1, input bit yu, input bit fl);
    int   sz;
    exp_t h;
    sz = qsize(d);
    check("ready", ready[d], sz < els(d));
    check("count", cnt[d], sz);
    check("valid", rv[d], sz != 0);
    if (sz != 0) begin
      h = (d == 0) ? q0[0] : q1[0];
      check("head_v", res[d].v, 1'b1);
      check("head_pc", res[d].pc, h.pc);
      check("head_isrc1", res[d].isrc1, h.isrc1);
      check("head_fsrc1", res[d].fsrc1, h.fsrc1);
    end else begin
      check("empty_res", res[d], '0);
    end
    pkt = p;
    bypass[0] = rs1;
    bypass[1] = ~rs1;
    bypass[2] = {rs1[31:0], rs1[63:32]};
    dv[d] = en;
    yumi[d] = yu;
    flush[d] = fl;
    #1 check("no_passthru", rv[d], sz != 0);
    @(posedge clk);
    if (fl) begin
      if (d == 0) q0.delete(); else q1.delete();
    end else begin
      if (yu && sz != 0) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (en && sz < els(d)) begin
        if (d == 0) q0.push_back('{p.pc, ei1, ef1}); else q1.push_back('{p.pc, ei1, ef1});
      end
    end
    #1;
    dv[d] = 1'b0;
    yumi[d] = 1'b0;
    flush[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic enq(input int d, input logic [38:0] pc, input logic [63:0] rs1, input bit yu);
    cycle(d, 1'b1, mk(pc), rs1, {rs1[63], rs1}, {1'b0, rs1}, yu, 1'b0);
  endtask

  task automatic idle(input int d, input bit yu);
    cycle(d, 1'b0, '0, 64'h0, '0, '0, yu, 1'b0);
  endtask

  initial begin
    bp_be_dispatch_pkt_s p;
    logic [63:0] r;

    reset = 1'b1;
    pkt = '0;
    bypass = '0;
    for (int d = 0; d < 2; d++) begin
      dv[d] = 1'b0; flush[d] = 1'b0; yumi[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", ready[d], 1'b0);
      check("rst_valid", rv[d], 1'b0);
      check("rst_count", cnt[d], 2'd0);
      check("rst_res_v", res[d].v, 1'b0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    idle(1, 1'b0);

    // A at 0x8000_0000 with rs1 = 5; visible next cycle
    enq(0, 39'h80000000, 64'h5, 1'b0);
    check("A_isrc2", res[0].isrc2, {1'b1, ~64'h5});
    check("A_isrc3", res[0].isrc3, {1'b0, 64'h0000_0005_0000_0000});
    enq(0, 39'h80000004, 64'h6, 1'b0);
    enq(0, 39'h80000008, 64'h7, 1'b0);
    idle(0, 1'b1);
    idle(0, 1'b1);
    idle(0, 1'b0);

    // integer word unboxing, signed and unsigned
    p = mk(39'h100); p.decode.irs1_tag = e_int_word;
    cycle(0, 1'b1, p, 64'h0000_0000_8000_0001, 65'h1_FFFF_FFFF_8000_0001, {1'b0, 64'h0000_0000_8000_0001}, 1'b0, 1'b0);
    p = mk(39'h104); p.decode.irs1_tag = e_int_word; p.decode.irs1_unsigned = 1'b1;
    cycle(0, 1'b1, p, 64'hFFFF_FFFF_8000_0001, 65'h0_0000_0000_8000_0001, {1'b0, 64'hFFFF_FFFF_8000_0001}, 1'b0, 1'b0);
    idle(0, 1'b1);
    idle(0, 1'b1);

    // FP unboxing: boxed 1.0f, unboxed single -> canonical NaN, 1.0 double
    p = mk(39'h200); p.decode.fmove_v = 1'b0; p.decode.frs1_tag = e_fp_sp;
    cycle(0, 1'b1, p, 64'hFFFF_FFFF_3F80_0000, {1'b1, 64'hFFFF_FFFF_3F80_0000}, 65'h0_8000_0000, 1'b0, 1'b0);
    p = mk(39'h204); p.decode.fmove_v = 1'b0; p.decode.frs1_tag = e_fp_sp;
    cycle(0, 1'b1, p, 64'h0000_0000_3F80_0000, {1'b0, 64'h0000_0000_3F80_0000}, 65'h0_E040_0000, 1'b1, 1'b0);
    p = mk(39'h208); p.decode.fmove_v = 1'b0; p.decode.frs1_tag = e_fp_dp;
    cycle(0, 1'b1, p, 64'h3FF0_0000_0000_0000, {1'b0, 64'h3FF0_0000_0000_0000}, 65'h0_8000_0000_0000_0000, 1'b1, 1'b0);
    idle(0, 1'b1);

    // flush with the queue full and a dispatch in the same cycle
    enq(0, 39'h300, 64'h30, 1'b0);
    enq(0, 39'h304, 64'h31, 1'b0);
    cycle(0, 1'b1, mk(39'h308), 64'h32, {1'b0, 64'h32}, {1'b0, 64'h32}, 1'b0, 1'b1);
    enq(0, 39'h30C, 64'h33, 1'b0);
    // flush with one entry, an accepted-looking dispatch and a yumi together
    cycle(0, 1'b1, mk(39'h310), 64'h34, {1'b0, 64'h34}, {1'b0, 64'h34}, 1'b1, 1'b1);
    idle(0, 1'b0);

    // depth 3: stream 10 packets through pointer wrap
    for (int i = 0; i < 10; i++) begin
      r = {$urandom, $urandom};
      enq(1, 39'h1000 + 39'(i * 4), r, i >= 2);
    end
    idle(1, 1'b1);
    idle(1, 1'b1);
    // fill to capacity; the fourth is refused
    for (int i = 0; i < 4; i++) enq(1, 39'h2000 + 39'(i * 4), 64'h40 + 64'(i), 1'b0);
    idle(1, 1'b1);

    // reset mid-operation discards everything
    reset = 1'b1;
    @(posedge clk);
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("midrst_ready", ready[1], 1'b0);
    check("midrst_count", cnt[1], 2'd0);
    check("midrst_valid", rv[1], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    idle(1, 1'b0);
    enq(1, 39'h3000, 64'h55, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
